// File: rtl/ibex_efpga_ctrl_pkg.sv
// Shared definitions for the execute-side eFPGA instruction controller:
// custom opcode, delay-field width and FSM state encoding.
package ibex_efpga_ctrl_pkg;

   localparam logic [6:0]  OPCODE_EFPGA  = 7'h0b;
   localparam int unsigned EFPGA_DELAY_W = 4;

   typedef logic [2:0] efpga_state_e;

   localparam efpga_state_e EFPGA_IDLE     = 3'd0;
   localparam efpga_state_e EFPGA_ISSUE    = 3'd1;
   localparam efpga_state_e EFPGA_WAIT_CNT = 3'd2;
   localparam efpga_state_e EFPGA_WAIT_ACK = 3'd3;
   localparam efpga_state_e EFPGA_DONE     = 3'd4;

endpackage

// File: rtl/ibex_efpga_timer.sv
// Loadable down-counter for fixed-delay ops plus an up-counter that bounds
// the wait for a fabric handshake; both report their terminal value as flags.
module ibex_efpga_timer
   import ibex_efpga_ctrl_pkg::*;
#(
   parameter int unsigned DELAY_W     = EFPGA_DELAY_W,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               load_i,
   input  logic [DELAY_W-1:0] load_val_i,
   input  logic               dec_i,
   input  logic               clr_tmo_i,
   input  logic               inc_tmo_i,
   output logic               expire_o,
   output logic               timeout_o
);

   localparam int unsigned      TMO_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

   logic [DELAY_W-1:0] cnt_q, cnt_d;
   logic [TMO_W-1:0]   tmo_q, tmo_d;

   always_comb begin
      // NOTE: each *_d starts from its hold value so no path leaves it unassigned (no latch).
      cnt_d = cnt_q;
      tmo_d = tmo_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - DELAY_W'(1);
      end
      if (clr_tmo_i) begin
         tmo_d = '0;
      end else if (inc_tmo_i) begin
         tmo_d = tmo_q + TMO_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      // NOTE: flops use <= so every register updates from pre-edge values.
      if (!rst_ni) begin
         cnt_q <= '0;
         tmo_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         tmo_q <= tmo_d;
      end
   end

   assign expire_o  = (cnt_q == DELAY_W'(1));
   assign timeout_o = (tmo_q == TMO_LAST);

endmodule

// File: rtl/ibex_efpga_ctrl.sv
// Launches one custom eFPGA operation per instruction, stalls ID until it
// completes (fixed delay or done handshake) and returns a registered result.
module ibex_efpga_ctrl
   import ibex_efpga_ctrl_pkg::*;
#(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned DELAY_W     = EFPGA_DELAY_W,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               efpga_en_i,
   input  logic [1:0]         efpga_op_i,
   input  logic [DELAY_W-1:0] efpga_delay_i,
   input  logic               flush_i,
   input  logic [DATA_W-1:0]  operand_a_i,
   input  logic [DATA_W-1:0]  operand_b_i,
   output logic [DATA_W-1:0]  efpga_a_o,
   output logic [DATA_W-1:0]  efpga_b_o,
   output logic [1:0]         efpga_op_o,
   output logic               efpga_start_o,
   input  logic [DATA_W-1:0]  efpga_result_i,
   input  logic               efpga_done_i,
   output logic               busy_o,
   output logic [DATA_W-1:0]  result_o,
   output logic               valid_o,
   output logic               timeout_o
);

   efpga_state_e       state_q, state_d;
   logic [DATA_W-1:0]  a_q, a_d;
   logic [DATA_W-1:0]  b_q, b_d;
   logic [1:0]         op_q, op_d;
   logic [DELAY_W-1:0] delay_q, delay_d;
   logic [DATA_W-1:0]  result_q, result_d;
   logic               tmo_flag_q, tmo_flag_d;

   logic tmr_load, tmr_dec, tmr_clr, tmr_inc;
   logic cnt_expire, tmo_expire;

   ibex_efpga_timer #(
      .DELAY_W     (DELAY_W),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timer (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .load_i     (tmr_load),
      .load_val_i (delay_q),
      .dec_i      (tmr_dec),
      .clr_tmo_i  (tmr_clr),
      .inc_tmo_i  (tmr_inc),
      .expire_o   (cnt_expire),
      .timeout_o  (tmo_expire)
   );

   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      op_d       = op_q;
      delay_d    = delay_q;
      result_d   = result_q;
      tmo_flag_d = tmo_flag_q;
      tmr_load   = 1'b0;
      tmr_dec    = 1'b0;
      tmr_clr    = 1'b0;
      tmr_inc    = 1'b0;

      // A flush wins everywhere: nothing is captured and no result is written.
      if (flush_i) begin
         state_d = EFPGA_IDLE;
      end else begin
         case (state_q)
            EFPGA_IDLE: begin
               if (efpga_en_i) begin
                  a_d     = operand_a_i;
                  b_d     = operand_b_i;
                  op_d    = efpga_op_i;
                  delay_d = efpga_delay_i;
                  state_d = EFPGA_ISSUE;
               end
            end
            EFPGA_ISSUE: begin
               tmr_load = 1'b1;
               tmr_clr  = 1'b1;
               if (delay_q != '0) begin
                  state_d = EFPGA_WAIT_CNT;
               end else if (efpga_done_i) begin
                  result_d   = efpga_result_i;
                  tmo_flag_d = 1'b0;
                  state_d    = EFPGA_DONE;
               end else begin
                  state_d = EFPGA_WAIT_ACK;
               end
            end
            EFPGA_WAIT_CNT: begin
               tmr_dec = 1'b1;
               if (cnt_expire) begin
                  result_d   = efpga_result_i;
                  tmo_flag_d = 1'b0;
                  state_d    = EFPGA_DONE;
               end
            end
            EFPGA_WAIT_ACK: begin
               if (efpga_done_i) begin
                  result_d   = efpga_result_i;
                  tmo_flag_d = 1'b0;
                  state_d    = EFPGA_DONE;
               end else if (tmo_expire) begin
                  // Timed-out ops still retire, writing 0 to rd.
                  result_d   = '0;
                  tmo_flag_d = 1'b1;
                  state_d    = EFPGA_DONE;
               end else begin
                  tmr_inc = 1'b1;
               end
            end
            EFPGA_DONE: begin
               state_d = EFPGA_IDLE;
            end
            default: begin
               state_d = EFPGA_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= EFPGA_IDLE;
         a_q        <= '0;
         b_q        <= '0;
         op_q       <= '0;
         delay_q    <= '0;
         result_q   <= '0;
         tmo_flag_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         op_q       <= op_d;
         delay_q    <= delay_d;
         result_q   <= result_d;
         tmo_flag_q <= tmo_flag_d;
      end
   end

   assign efpga_a_o     = a_q;
   assign efpga_b_o     = b_q;
   assign efpga_op_o    = op_q;
   assign result_o      = result_q;
   assign efpga_start_o = (state_q == EFPGA_ISSUE) && !flush_i;
   assign valid_o       = (state_q == EFPGA_DONE) && !flush_i;
   assign timeout_o     = (state_q == EFPGA_DONE) && tmo_flag_q && !flush_i;
   // ID is released in DONE so the retiring instruction advances that cycle.
   assign busy_o        = (state_q == EFPGA_IDLE) ? efpga_en_i : (state_q != EFPGA_DONE);

endmodule
